// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// Module   : fetch_pkg
// Purpose  : Shared widths, reset default and state type for the fetch stage.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;

   typedef enum logic [0:0] {
      FETCH_RUN  = 1'b0,
      FETCH_HALT = 1'b1
   } fetch_state_e;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_out_reg.sv
// ---------------------------------------------------------------------------
// Module   : fetch_out_reg
// Purpose  : Valid/ready output slot holding one fetched instruction and its PC.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_out_reg
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               flush_i,
   input  logic               ready_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [ADDR_W-1:0]  pc_i,
   output logic               valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pc_o
);

   logic               valid_q, valid_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  pc_q,    pc_d;

   // Flush wins over load; an unloaded slot empties once decode takes it.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule : fetch_out_reg

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: PC, run/halt control, redirect handling
//            and issue counting. FETCH_ZERO_HALT_EN makes a zero word end fetch.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       MEM_DEPTH = 64,
   parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [ADDR_W-1:0]  pc_o,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic               redirect_valid_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [INSTR_W-1:0] out_instr_o,
   output logic [ADDR_W-1:0]  out_pc_o,
   output logic               halted_o,
   output logic [31:0]        issue_count_o
);

   localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_DEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;
   logic [31:0]       issue_cnt_q, issue_cnt_d;

   logic handshake;
   logic slot_free;
   logic in_range;
   logic zero_word;
   logic load;
   logic flush;

   assign handshake = out_valid_o && out_ready_i;
   assign slot_free = !out_valid_o || out_ready_i;
   assign in_range  = (pc_q < MEM_LIMIT);

`ifdef FETCH_ZERO_HALT_EN
   assign zero_word = (instr_i == '0);
`else
   assign zero_word = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      halted_d    = halted_q;
      load        = 1'b0;
      flush       = 1'b0;
      issue_cnt_d = handshake ? issue_cnt_q + 32'd1 : issue_cnt_q;

      // Redirect overrides run/halt; a same-cycle handshake is still counted above.
      if (redirect_valid_i) begin
         pc_d     = redirect_pc_i;
         flush    = 1'b1;
         state_d  = FETCH_RUN;
         halted_d = 1'b0;
      end else begin
         case (state_q)
            FETCH_RUN: begin
               if (!in_range) begin
                  state_d  = FETCH_HALT;
                  halted_d = 1'b1;
               end else if (slot_free) begin
                  if (zero_word) begin
                     state_d  = FETCH_HALT;
                     halted_d = 1'b1;
                  end else begin
                     load = 1'b1;
                     pc_d = pc_q + ADDR_W'(1);
                  end
               end
            end
            FETCH_HALT: begin
               state_d = FETCH_HALT;
            end
            default: begin
               state_d = FETCH_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FETCH_RUN;
         pc_q        <= RESET_PC;
         halted_q    <= 1'b0;
         issue_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         halted_q    <= halted_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   fetch_out_reg u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .flush_i (flush),
      .ready_i (out_ready_i),
      .instr_i (instr_i),
      .pc_i    (pc_q),
      .valid_o (out_valid_o),
      .instr_o (out_instr_o),
      .pc_o    (out_pc_o)
   );

   assign pc_o          = pc_q;
   assign halted_o      = halted_q;
   assign issue_count_o = issue_cnt_q;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit with a cycle-level reference model.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_unit;

   localparam int unsigned DEPTH  = 64;
   localparam logic [31:0] RST_PC = 32'd0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_o;
   logic [31:0] instr_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_instr_o;
   logic [31:0] out_pc_o;
   logic        halted_o;
   logic [31:0] issue_count_o;

   logic [31:0] mem [0:127];

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] issued [$];

   always #5 clk = ~clk;

   fetch_unit #(
      .MEM_DEPTH (DEPTH),
      .RESET_PC  (RST_PC)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pc_o             (pc_o),
      .instr_i          (instr_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .out_instr_o      (out_instr_o),
      .out_pc_o         (out_pc_o),
      .halted_o         (halted_o),
      .issue_count_o    (issue_count_o)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd128) return mem[a[6:0]];
      return 32'hBAD0_0000;
   endfunction

   always_comb instr_i = (pc_o < 32'd128) ? mem[pc_o[6:0]] : 32'hBAD0_0000;

   // Reference model: next outputs straight from the stage's rules.
   logic [31:0] m_pc, m_instr, m_opc, m_cnt, m_word;
   logic        m_valid, m_halt, m_hs, m_free, m_zero_end;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc    = RST_PC;
         m_valid = 1'b0;
         m_instr = '0;
         m_opc   = '0;
         m_halt  = 1'b0;
         m_cnt   = '0;
      end else begin
         m_hs   = m_valid && out_ready_i;
         m_free = !m_valid || out_ready_i;
         m_word = mem_word(m_pc);
`ifdef FETCH_ZERO_HALT_EN
         m_zero_end = (m_word == 32'd0);
`else
         m_zero_end = 1'b0;
`endif
         if (m_hs) m_cnt = m_cnt + 32'd1;
         if (redirect_valid_i) begin
            m_pc    = redirect_pc_i;
            m_valid = 1'b0;
            m_halt  = 1'b0;
         end else if (m_halt) begin
            if (m_hs) m_valid = 1'b0;
         end else if (m_pc >= DEPTH) begin
            if (m_hs) m_valid = 1'b0;
            m_halt = 1'b1;
         end else if (m_free) begin
            if (m_zero_end) begin
               m_valid = 1'b0;
               m_halt  = 1'b1;
            end else begin
               m_valid = 1'b1;
               m_instr = m_word;
               m_opc   = m_pc;
               m_pc    = m_pc + 32'd1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("pc_o", pc_o, m_pc);
      chk("out_valid_o", {31'd0, out_valid_o}, {31'd0, m_valid});
      chk("halted_o", {31'd0, halted_o}, {31'd0, m_halt});
      chk("issue_count_o", issue_count_o, m_cnt);
      if (m_valid) begin
         chk("out_instr_o", out_instr_o, m_instr);
         chk("out_pc_o", out_pc_o, m_opc);
      end
      if (out_valid_o && out_ready_i) issued.push_back(out_pc_o);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int n4;

   initial begin
      rst_n            = 1'b0;
      out_ready_i      = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = '0;
      for (int i = 0; i < 128; i++)
         mem[i] = (i < 64) ? 32'(i + 1) : (32'hFFFF_0000 | 32'(i));

      repeat (2) tick();
      chk("rst pc_o", pc_o, 32'd0);
      chk("rst out_valid_o", {31'd0, out_valid_o}, 32'd0);
      chk("rst out_pc_o", out_pc_o, 32'd0);
      chk("rst issue_count_o", issue_count_o, 32'd0);

      // Streaming from reset
      out_ready_i = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();
      chk("first out_pc", out_pc_o, 32'd0);
      chk("first out_instr", out_instr_o, 32'd1);
      tick();
      chk("second out_instr", out_instr_o, 32'd2);
      tick();
      chk("third out_instr", out_instr_o, 32'd3);
      chk("third out_pc", out_pc_o, 32'd2);
      tick();
      chk("count after three", issue_count_o, 32'd3);

      // Backpressure holding PC 5
      repeat (2) tick();
      chk("bp slot pc", out_pc_o, 32'd5);
      out_ready_i = 1'b0;
      repeat (4) tick();
      chk("bp out_pc held", out_pc_o, 32'd5);
      chk("bp pc_o held", pc_o, 32'd6);
      chk("bp count held", issue_count_o, 32'd5);
      out_ready_i = 1'b1;
      tick();
      chk("bp resume pc", out_pc_o, 32'd6);
      chk("bp resume count", issue_count_o, 32'd6);

      // Redirect coinciding with handshake of PC 3
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'd3;
      tick();
      redirect_valid_i = 1'b0;
      tick();
      chk("pre-redirect slot", out_pc_o, 32'd3);
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'd10;
      tick();
      redirect_valid_i = 1'b0;
      chk("redir flush valid", {31'd0, out_valid_o}, 32'd0);
      chk("redir pc_o", pc_o, 32'd10);
      chk("redir count", issue_count_o, 32'd8);
      chk("redir delivered pc3", issued[$], 32'd3);
      tick();
      chk("redir target pc", out_pc_o, 32'd10);
      chk("redir target instr", out_instr_o, 32'd11);

      // Run off the end of memory
      for (int i = 0; i < 200 && !halted_o; i++) tick();
      chk("end halted", {31'd0, halted_o}, 32'd1);
      chk("end last issued", issued[$], 32'd63);
      repeat (3) tick();
      chk("end pc_o held", pc_o, 32'd64);
      chk("end valid low", {31'd0, out_valid_o}, 32'd0);

      // Restart at 0 with a zero word at address 4
      mem[4] = 32'd0;
      issued.delete();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'd0;
      tick();
      redirect_valid_i = 1'b0;
      chk("restart halted clear", {31'd0, halted_o}, 32'd0);
      tick();
      chk("restart instr0", out_instr_o, 32'd1);
      repeat (4) tick();
`ifdef FETCH_ZERO_HALT_EN
      chk("zero halt halted", {31'd0, halted_o}, 32'd1);
      chk("zero halt pc_o", pc_o, 32'd4);
      tick();
      n4 = 0;
      foreach (issued[k]) if (issued[k] == 32'd4) n4++;
      chk("zero word never issued", 32'(n4), 32'd0);
      chk("zero halt issued count", 32'(issued.size()), 32'd4);
`else
      chk("zero nop pc", out_pc_o, 32'd4);
      chk("zero nop instr", out_instr_o, 32'd0);
      tick();
      chk("zero nop delivered", issued[4], 32'd4);
`endif

      // Asynchronous reset with a full slot
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'd20;
      tick();
      redirect_valid_i = 1'b0;
      tick();
      chk("pre-reset slot pc", out_pc_o, 32'd20);
      chk("pre-reset slot instr", out_instr_o, 32'd21);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst valid", {31'd0, out_valid_o}, 32'd0);
      chk("async rst pc_o", pc_o, RST_PC);
      chk("async rst out_pc", out_pc_o, 32'd0);
      chk("async rst out_instr", out_instr_o, 32'd0);
      chk("async rst count", issue_count_o, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();
      chk("post-reset pc", out_pc_o, 32'd0);
      chk("post-reset instr", out_instr_o, 32'd1);
      tick();
      chk("post-reset count", issue_count_o, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_fetch_unit

`default_nettype wire
